// File: rtl/multicycle_ctrl.sv
// Purpose: multi-cycle control FSM for addi/lw/beq/bne over a shared ALU/memory/sign-extend datapath.
// Latency: addi 4, lw 5, branch 3 cycles with zero-wait memory; each mem_ready stall adds one cycle.
// Backpressure: mem_req held in FETCH/MEM_READ until mem_ready; optional counters under PERF_CNT_EN.
module multicycle_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  mem_ready,
  input  logic                  eq,
  output logic                  mem_req,
  output logic                  AdrSrc,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  PCSrc,
  output logic                  ImmSrc,
  output logic                  ALUSrc,
  output logic [2:0]            ALUctrl,
  output logic                  RegWrite,
  output logic                  ResultSrc,
`ifdef PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]  cycle_cnt,
  output logic [CNT_WIDTH-1:0]  instret_cnt,
`endif
  output logic                  illegal
);

  localparam logic [2:0] FETCH    = 3'd0;
  localparam logic [2:0] DECODE   = 3'd1;
  localparam logic [2:0] EXEC_I   = 3'd2;
  localparam logic [2:0] WB_ALU   = 3'd3;
  localparam logic [2:0] MEM_ADDR = 3'd4;
  localparam logic [2:0] MEM_READ = 3'd5;
  localparam logic [2:0] WB_MEM   = 3'd6;
  localparam logic [2:0] BRANCH   = 3'd7;

  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Register, immediate and upper funct bits are datapath concerns, not control.
  logic unused_instr;
  assign unused_instr = ^{instr[DATA_WIDTH-1:15], instr[11:7]};

  // State register; reset returns to FETCH and abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Next-state decode; mem_ready only matters while a memory request is outstanding.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:    state_nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_ADDI:   state_nxt = EXEC_I;
          OP_LW:     state_nxt = MEM_ADDR;
          OP_BRANCH: state_nxt = BRANCH;
          default:   state_nxt = FETCH;
        endcase
      end
      EXEC_I:   state_nxt = WB_ALU;
      WB_ALU:   state_nxt = FETCH;
      MEM_ADDR: state_nxt = MEM_READ;
      MEM_READ: state_nxt = mem_ready ? WB_MEM : MEM_READ;
      WB_MEM:   state_nxt = FETCH;
      BRANCH:   state_nxt = FETCH;
      default:  state_nxt = FETCH;
    endcase
  end

  // Control outputs; reset overrides everything so no write can leak out mid-abort.
  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    ImmSrc    = 1'b1;
    ALUSrc    = 1'b0;
    ALUctrl   = ALU_ADD;
    RegWrite  = 1'b0;
    ResultSrc = 1'b0;
    illegal   = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        IRWrite = mem_ready;
      end
      DECODE: begin
        if (opcode != OP_ADDI && opcode != OP_LW && opcode != OP_BRANCH) begin
          // Unsupported opcode: skip it with a plain PC+4 advance.
          illegal = 1'b1;
          PCWrite = 1'b1;
        end
      end
      EXEC_I, MEM_ADDR: begin
        ALUSrc  = 1'b1;
        ALUctrl = ALU_ADD;
      end
      WB_ALU: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
      end
      MEM_READ: begin
        // Keep the address computation driven so the ALU result stays valid across stalls.
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        ALUSrc  = 1'b1;
        ALUctrl = ALU_ADD;
      end
      WB_MEM: begin
        RegWrite  = 1'b1;
        ResultSrc = 1'b1;
        PCWrite   = 1'b1;
      end
      BRANCH: begin
        ImmSrc  = 1'b0;
        ALUctrl = ALU_SUB;
        PCWrite = 1'b1;
        case (funct3)
          3'b000:  PCSrc = eq;
          3'b001:  PCSrc = ~eq;
          default: illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
    if (rst) begin
      mem_req   = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCSrc     = 1'b0;
      ImmSrc    = 1'b0;
      ALUSrc    = 1'b0;
      ALUctrl   = 3'b000;
      RegWrite  = 1'b0;
      ResultSrc = 1'b0;
      illegal   = 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  // Free-running cycle and retired-instruction counters; both wrap silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if (PCWrite && !illegal) instret_cnt <= instret_cnt + CNT_WIDTH'(1);
    end
  end
`else
  localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: hand-computed control vectors per cycle.
// Inputs driven and outputs sampled on the falling edge, away from the state update.
// Counter checks are compiled in only when PERF_CNT_EN is defined.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        eq;
  logic        mem_req, AdrSrc, IRWrite, PCWrite, PCSrc, ImmSrc, ALUSrc;
  logic [2:0]  ALUctrl;
  logic        RegWrite, ResultSrc, illegal;
`ifdef PERF_CNT_EN
  logic [3:0]  cycle_cnt, instret_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  multicycle_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .eq(eq),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc), .ALUctrl(ALUctrl),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc),
`ifdef PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] outv;
  assign outv = {mem_req, AdrSrc, IRWrite, PCWrite, PCSrc, ImmSrc, ALUSrc,
                 ALUctrl, RegWrite, ResultSrc, illegal};

  // Pack expected controls in the same order as outv.
  function automatic logic [12:0] ov(input logic mr, input logic as_, input logic ir,
                                     input logic pw, input logic ps, input logic is_,
                                     input logic als, input logic [2:0] ac,
                                     input logic rw, input logic rsrc, input logic il);
    return {mr, as_, ir, pw, ps, is_, als, ac, rw, rsrc, il};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs for the current cycle, check its controls, then move to the next cycle.
  task automatic step(input string tag, input logic mr, input logic e, input logic [12:0] expv);
    mem_ready = mr;
    eq        = e;
    #1;
    chk(tag, {3'b000, outv}, {3'b000, expv});
    @(negedge clk);
  endtask

  // Two reset cycles with outputs forced low; mem_ready high to show it is ignored.
  task automatic do_reset(input string tag);
    rst       = 1'b1;
    mem_ready = 1'b1;
    eq        = 1'b1;
    #1;
    chk({tag, "_out0"}, {3'b000, outv}, 16'h0000);
    @(negedge clk);
    #1;
    chk({tag, "_out1"}, {3'b000, outv}, 16'h0000);
`ifdef PERF_CNT_EN
    chk({tag, "_cyc"}, {12'h000, cycle_cnt}, 16'h0000);
    chk({tag, "_ret"}, {12'h000, instret_cnt}, 16'h0000);
`endif
    rst = 1'b0;
  endtask

  logic [12:0] f_rdy, f_wait, dec, dec_ill, exi, wba, mrd, wbm;

  initial begin
    f_rdy   = ov(1,0,1,0,0,1,0,3'b000,0,0,0);
    f_wait  = ov(1,0,0,0,0,1,0,3'b000,0,0,0);
    dec     = ov(0,0,0,0,0,1,0,3'b000,0,0,0);
    dec_ill = ov(0,0,0,1,0,1,0,3'b000,0,0,1);
    exi     = ov(0,0,0,0,0,1,1,3'b000,0,0,0);
    wba     = ov(0,0,0,1,0,1,0,3'b000,1,0,0);
    mrd     = ov(1,1,0,0,0,1,1,3'b000,0,0,0);
    wbm     = ov(0,0,0,1,0,1,0,3'b000,1,1,0);

    rst = 1'b1; instr = 32'h0; mem_ready = 1'b0; eq = 1'b0;
    @(negedge clk);
    do_reset("rst_init");

    // addi x1,x0,5: write-back and PC update in cycle 4
    instr = 32'h00500093;
    step("addi_fetch", 1, 0, f_rdy);
    step("addi_dec",   0, 0, dec);
    step("addi_exec",  0, 0, exi);
    step("addi_wb",    0, 0, wba);
    step("addi_next",  0, 0, f_wait);

    // lw x2,8(x1) with three memory stalls: 8 cycles
    instr = 32'h0080A103;
    step("lw_fetch",  1, 0, f_rdy);
    step("lw_dec",    0, 0, dec);
    step("lw_addr",   0, 0, exi);
    step("lw_rd_w0",  0, 0, mrd);
    step("lw_rd_w1",  0, 0, mrd);
    step("lw_rd_w2",  0, 0, mrd);
    step("lw_rd_ok",  1, 0, mrd);
    step("lw_wb",     0, 0, wbm);

    // beq taken / not taken
    instr = 32'h00208463;
    step("beq1_fetch", 1, 0, f_rdy);
    step("beq1_dec",   0, 1, dec);
    step("beq1_br",    0, 1, ov(0,0,0,1,1,0,0,3'b001,0,0,0));
    step("beq0_fetch", 1, 0, f_rdy);
    step("beq0_dec",   0, 0, dec);
    step("beq0_br",    0, 0, ov(0,0,0,1,0,0,0,3'b001,0,0,0));

    // bne taken / not taken
    instr = 32'h00209463;
    step("bne0_fetch", 1, 0, f_rdy);
    step("bne0_dec",   0, 0, dec);
    step("bne0_br",    0, 0, ov(0,0,0,1,1,0,0,3'b001,0,0,0));
    step("bne1_fetch", 1, 1, f_rdy);
    step("bne1_dec",   0, 1, dec);
    step("bne1_br",    0, 1, ov(0,0,0,1,0,0,0,3'b001,0,0,0));

    // unsupported opcode 0110111: skipped in DECODE
    instr = 32'h000000B7;
    step("ill_op_fetch", 1, 0, f_rdy);
    step("ill_op_dec",   0, 0, dec_ill);
    step("ill_op_next",  0, 0, f_wait);

    // branch with funct3=010: illegal, PC+4 even with eq high
    instr = 32'h0020A463;
    step("ill_f3_fetch", 1, 1, f_rdy);
    step("ill_f3_dec",   0, 1, dec);
    step("ill_f3_br",    0, 1, ov(0,0,0,1,0,0,0,3'b001,0,0,1));
    step("ill_f3_next",  0, 0, f_wait);

    // reset during MEM_READ aborts the load and restarts at FETCH
    instr = 32'h0080A103;
    step("abort_fetch", 1, 0, f_rdy);
    step("abort_dec",   0, 0, dec);
    step("abort_addr",  0, 0, exi);
    step("abort_rd",    0, 0, mrd);
    do_reset("rst_mid");
    step("abort_after", 0, 0, f_wait);

`ifdef PERF_CNT_EN
    // 20 cycles of back-to-back addi: 4-bit cycle count wraps to 4, five retired
    do_reset("rst_perf");
    instr = 32'h00500093;
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'b1;
      @(negedge clk);
    end
    #1;
    chk("perf_cycle",   {12'h000, cycle_cnt},   16'd4);
    chk("perf_instret", {12'h000, instret_cnt}, 16'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
